// File: rtl/ifu_branch_predictor_pkg.sv
// ifu_branch_predictor_pkg
//   Shared definitions for the IF-stage gshare branch predictor:
//   - RISC-V opcode constants for conditional branches and JAL
//   - BHT counter reset value (weakly not-taken)
//   - clear-FSM state type
//   - immediate-extraction helpers and the 2-bit saturating counter update
package ifu_branch_predictor_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [1:0] BHT_RST    = 2'b01;

  typedef enum logic {
    BHT_CLR,
    BHT_RUN
  } bht_state_e;

  // B-type immediate, sign-extended to 32 bits.
  function automatic logic [31:0] br_imm(input logic [31:0] inst);
    logic unused_fields;
    unused_fields = ^{inst[24:12], inst[6:0]};
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic [31:0] jal_imm(input logic [31:0] inst);
    logic unused_fields;
    unused_fields = ^inst[11:0];
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // 2-bit saturating counter: 11 stays 11 on taken, 00 stays 00 on not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'b11) res = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/ifu_branch_predictor_if.sv
// ifu_branch_predictor_if
//   Bundles the predictor's fetch, prediction, resolution-update and
//   statistics signals.
//   master : IFU/IDU side (drives fetch, flush and update; reads predictions/stats)
//   slave  : the predictor itself
interface ifu_branch_predictor_if #(
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
);
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             pred_redirect;
  logic [31:0]      pred_pc;
  logic             pred_br_taken;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispred;
  logic             flush;
  logic [CNT_W-1:0] stat_br;
  logic [CNT_W-1:0] stat_mis;

  modport master (
    output if_valid, if_pc, if_inst, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred, flush,
    input  pred_redirect, pred_pc, pred_br_taken, pred_ghr, stat_br, stat_mis
  );

  modport slave (
    input  if_valid, if_pc, if_inst, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispred, flush,
    output pred_redirect, pred_pc, pred_br_taken, pred_ghr, stat_br, stat_mis
  );
endinterface

// File: rtl/ifu_branch_predictor_bht.sv
// bpu_bht
//   Branch history table of 2-bit saturating counters.
//   clk, rst : clock and synchronous active-high reset
//   rd_idx   : asynchronous lookup index, rd_cnt the counter at that index
//   wr_en    : apply one saturating update at wr_idx with outcome wr_taken
//   ready    : table is usable (clear FSM in RUN)
//   Tables of up to 64 entries clear in the reset cycle itself; larger
//   tables are swept one entry per cycle in CLR before entering RUN.
module bpu_bht
  import ifu_branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  output logic             ready
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam bit SWEEP   = (IDX_W > 6);

  logic [1:0]       bht [ENTRIES];
  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // Clear-FSM state register; a small table is already clear after the
  // reset cycle so it skips straight to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SWEEP ? BHT_CLR : BHT_RUN;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep walks every index once, then hands the table over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      BHT_CLR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = BHT_RUN;
      end
      BHT_RUN: ;
      default: state_d = BHT_CLR;
    endcase
  end

  // Counter array: bulk clear, sweep clear, or one read-modify-write update.
  always_ff @(posedge clk) begin
    if (rst && !SWEEP) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= BHT_RST;
    end else if (state_q == BHT_CLR) begin
      bht[clr_idx_q] <= BHT_RST;
    end else if (wr_en && !rst) begin
      bht[wr_idx] <= sat_update(bht[wr_idx], wr_taken);
    end
  end

  // No bypass: a same-cycle update is only visible from the next cycle.
  assign rd_cnt = bht[rd_idx];
  assign ready  = (state_q == BHT_RUN);

endmodule

// File: rtl/ifu_branch_predictor.sv
// ifu_branch_predictor
//   IF-stage gshare branch predictor. Predecodes the fetched instruction,
//   redirects on predicted-taken branches and on every JAL, and learns
//   from resolved branches returned by the IDU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fetch (if_*), flush, predictions (pred_*),
//              resolution update (upd_*) and statistics (stat_*)
module ifu_branch_predictor
  import ifu_branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  ifu_branch_predictor_if.slave bus
);
  logic [GHR_W-1:0] ghr_q;
  logic [CNT_W-1:0] stat_br_q;
  logic [CNT_W-1:0] stat_mis_q;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       lookup_cnt;
  logic             bht_ready;
  logic             upd_fire;
  logic [6:0]       opcode;
  logic             unused_upd_pc;

  assign opcode     = bus.if_inst[6:0];
  assign lookup_idx = bus.if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign upd_idx    = bus.upd_pc[IDX_W+1:2] ^ IDX_W'(bus.upd_ghr);
  assign upd_fire   = bus.upd_valid && bht_ready;
  assign unused_upd_pc = ^{bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

  bpu_bht #(.IDX_W(IDX_W)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_idx),
    .rd_cnt   (lookup_cnt),
    .wr_en    (upd_fire),
    .wr_idx   (upd_idx),
    .wr_taken (bus.upd_taken),
    .ready    (bht_ready)
  );

  // Predecode and prediction; everything is quiet on an invalid, flushed
  // or still-clearing fetch.
  always_comb begin
    bus.pred_redirect = 1'b0;
    bus.pred_br_taken = 1'b0;
    bus.pred_pc       = '0;
    bus.pred_ghr      = ghr_q;
    if (bus.if_valid && !bus.flush && bht_ready) begin
      if (opcode == OPC_BRANCH) begin
        bus.pred_br_taken = lookup_cnt[1];
        bus.pred_redirect = lookup_cnt[1];
        bus.pred_pc       = bus.if_pc + br_imm(bus.if_inst);
      end else if (opcode == OPC_JAL) begin
        bus.pred_redirect = 1'b1;
        bus.pred_pc       = bus.if_pc + jal_imm(bus.if_inst);
      end
    end
  end

  // Non-speculative history and statistics, advanced only by resolved branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q      <= '0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (upd_fire) begin
      ghr_q     <= {ghr_q[GHR_W-2:0], bus.upd_taken};
      stat_br_q <= stat_br_q + 1'b1;
      if (bus.upd_mispred) stat_mis_q <= stat_mis_q + 1'b1;
    end
  end

  assign bus.stat_br  = stat_br_q;
  assign bus.stat_mis = stat_mis_q;

endmodule
